seg7_scan: RTL and testbench

//  Time-multiplexed hex driver for a common-anode 7-segment display bank.

---
 rtl/seg7_scan.sv | 165 ++++++++++++++++
 tb/tb_seg7_scan.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// Time-multiplexed hex driver for a common-anode 7-segment bank. It scans one digit per tick,
// inserts dark gaps between digits, and swaps in newly loaded values only at frame boundaries.
module seg7_scan #(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    load_ack,
    output logic                    frame_done
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
    localparam logic [3:0]    BLANK_LAST = (BLANK_CYCLES == 0) ? 4'd0 : 4'(BLANK_CYCLES - 1);

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    logic [1:0]              state;
    logic [IW-1:0]           idx;
    logic [3:0]              blank_cnt;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [4*NUM_DIGITS-1:0] active_val;
    logic [NUM_DIGITS-1:0]   active_dp;
    logic                    pending;

    logic [IW-1:0]         next_idx;
    logic                  wrap;
    logic [1:0]            after_tick;
    logic [NUM_DIGITS-1:0] lz_run;
    logic                  digit_blank;
    logic [3:0]            cur_nib;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    assign next_idx   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    assign wrap       = tick && (state != ST_OFF) && (idx == LAST_IDX);
    assign after_tick = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
    assign cur_nib    = active_val[4*idx +: 4];

    // lz_run[i] is set when digit i and every digit above it hold zero.
    always_comb begin : lz_scan
        logic all_zero;
        // NOTE: every comb output gets a value before any branch or loop, so no latch is inferred;
        // blocking '=' is correct here because the loop carries all_zero from one digit to the next.
        all_zero = 1'b1;
        lz_run   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero  = all_zero && (active_val[4*i +: 4] == 4'h0);
            lz_run[i] = all_zero;
        end
    end

    assign digit_blank = blank_lz && (idx != '0) && lz_run[idx];

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values;
    // that is what lets a load on the wrap cycle transfer the old shadow while capturing the new one.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the value registers are ordinary flops, not a RAM, so they reset to zero with
            // everything else and the display never starts from garbage.
            state      <= ST_OFF;
            idx        <= '0;
            blank_cnt  <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            active_val <= '0;
            active_dp  <= '0;
            pending    <= 1'b0;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
            end
            if (load)
                pending <= 1'b1;
            else if (wrap)
                pending <= 1'b0;
            if (wrap && pending) begin
                active_val <= shadow_val;
                active_dp  <= shadow_dp;
            end
            frame_done <= wrap;
            load_ack   <= wrap && pending;

            case (state)
                ST_OFF: begin
                    if (tick) begin
                        idx       <= '0;
                        blank_cnt <= '0;
                        state     <= after_tick;
                    end
                end
                ST_BLANK: begin
                    if (tick) begin
                        idx       <= next_idx;
                        blank_cnt <= '0;
                    end else if (blank_cnt == BLANK_LAST) begin
                        state <= ST_SHOW;
                    end else begin
                        blank_cnt <= blank_cnt + 4'd1;
                    end
                end
                ST_SHOW: begin
                    if (tick) begin
                        idx       <= next_idx;
                        blank_cnt <= '0;
                        state     <= after_tick;
                    end
                end
                default: state <= ST_OFF;
            endcase
        end
    end

    // Outputs are registered from the current state, so they trail a state/index change by one clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else if (state == ST_SHOW) begin
            an  <= ~(NUM_DIGITS'(1) << idx);
            seg <= digit_blank ? 7'h7F : hex_to_seg(cur_nib);
            dp  <= ~active_dp[idx];
        end else begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan (4 digits, 2 blank cycles): a vector table of loaded values with
// hand-decoded digits, plus sequences for wrap-cycle loads, held ticks and mid-scan reset.
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        load_ack;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0][6:0] cur_seg;
    logic [3:0]      cur_dp;

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      dp_in;
        logic            blz;
        logic [3:0][6:0] seg;
        logic [3:0]      dpo;
    } vec_t;

    vec_t vecs [6];

    seg7_scan #(.NUM_DIGITS(4), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .load_ack   (load_ack),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic show_check(input int d, input string tag);
        logic [3:0] exp_an;
        exp_an = ~(4'b0001 << d);
        check($sformatf("%s an d%0d", tag, d), an, exp_an);
        check($sformatf("%s seg d%0d", tag, d), seg, cur_seg[d]);
        check($sformatf("%s dp d%0d", tag, d), dp, cur_dp[d]);
    endtask

    // One tick (optionally with load), two dark clks, then the new digit; 8 clks in total.
    task automatic step_digit(input logic ld, input logic blz_new, input logic exp_fd,
                              input logic exp_la, input int d, input string tag);
        tick = 1'b1;
        load = ld;
        @(negedge clk);
        check($sformatf("%s frame_done d%0d", tag, d), frame_done, exp_fd);
        check($sformatf("%s load_ack d%0d", tag, d), load_ack, exp_la);
        tick     = 1'b0;
        load     = 1'b0;
        blank_lz = blz_new;
        @(negedge clk);
        check($sformatf("%s dark1 d%0d", tag, d), an, 4'hF);
        @(negedge clk);
        check($sformatf("%s dark2 d%0d", tag, d), an, 4'hF);
        @(negedge clk);
        show_check(d, tag);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{16'h12AF, 4'b0100, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1011};
        vecs[1] = '{16'h0030, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h30, 7'h40}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b1000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0111};
        vecs[3] = '{16'h8C5E, 4'b0001, 1'b1, {7'h00, 7'h46, 7'h12, 7'h06}, 4'b1110};
        vecs[4] = '{16'h0B07, 4'b0000, 1'b1, {7'h7F, 7'h03, 7'h40, 7'h78}, 4'b1111};
        vecs[5] = '{16'h4D69, 4'b0010, 1'b0, {7'h19, 7'h21, 7'h02, 7'h10}, 4'b1101};

        rst = 1'b1; tick = 1'b0; load = 1'b0; blank_lz = 1'b0; value = '0; dp_in = '0;
        repeat (2) @(negedge clk);
        check("reset an", an, 4'hF);
        check("reset seg", seg, 7'h7F);
        check("reset dp", dp, 1'b1);
        check("reset load_ack", load_ack, 1'b0);
        check("reset frame_done", frame_done, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("off an", an, 4'hF);

        // First frame shows the reset value (all zeros, no blanking).
        cur_seg = {4{7'h40}};
        cur_dp  = 4'hF;
        for (int d = 0; d < 4; d++) step_digit(1'b0, 1'b0, 1'b0, 1'b0, d, "init");

        for (int v = 0; v < 6; v++) begin
            step_digit(1'b0, blank_lz, 1'b1, 1'b0, 0, "pre");
            step_digit(1'b0, blank_lz, 1'b0, 1'b0, 1, "pre");
            value = vecs[v].value;
            dp_in = vecs[v].dp_in;
            load  = 1'b1;
            @(negedge clk);
            load  = 1'b0;
            value = 16'hDEAD;
            dp_in = 4'hF;
            show_check(1, "hold");
            step_digit(1'b0, blank_lz, 1'b0, 1'b0, 2, "pre");
            step_digit(1'b0, blank_lz, 1'b0, 1'b0, 3, "pre");
            cur_seg = vecs[v].seg;
            cur_dp  = vecs[v].dpo;
            step_digit(1'b0, vecs[v].blz, 1'b1, 1'b1, 0, $sformatf("vec%0d", v));
            for (int d = 1; d < 4; d++) step_digit(1'b0, vecs[v].blz, 1'b0, 1'b0, d, $sformatf("vec%0d", v));
        end

        // Load on the wrap cycle: pending 1111 transfers now, 5555 on the following wrap.
        value = 16'h1111; dp_in = 4'h0; load = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        value = 16'h5555;
        cur_seg = {4{7'h79}};
        cur_dp  = 4'hF;
        step_digit(1'b1, 1'b0, 1'b1, 1'b1, 0, "wrapload1");
        value = 16'hDEAD;
        for (int d = 1; d < 4; d++) step_digit(1'b0, 1'b0, 1'b0, 1'b0, d, "wrapload1");
        cur_seg = {4{7'h12}};
        step_digit(1'b0, 1'b0, 1'b1, 1'b1, 0, "wrapload2");
        for (int d = 1; d < 4; d++) step_digit(1'b0, 1'b0, 1'b0, 1'b0, d, "wrapload2");

        // Tick held for three clks from digit 0 lands on digit 3 with no overlap of anodes.
        step_digit(1'b0, 1'b0, 1'b1, 1'b0, 0, "held_pre");
        tick = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 2) tick = 1'b0;
            check($sformatf("held one_anode s%0d", k), ($countones(~an) <= 1), 1'b1);
            check($sformatf("held frame_done s%0d", k), frame_done, 1'b0);
        end
        show_check(3, "held");
        repeat (4) @(negedge clk);

        // Reset while showing digit 2 with a load pending: the pending value must be dropped.
        step_digit(1'b0, 1'b0, 1'b1, 1'b0, 0, "mid");
        step_digit(1'b0, 1'b0, 1'b0, 1'b0, 1, "mid");
        step_digit(1'b0, 1'b0, 1'b0, 1'b0, 2, "mid");
        value = 16'h9999; dp_in = 4'h0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        check("midrst an", an, 4'hF);
        check("midrst seg", seg, 7'h7F);
        check("midrst dp", dp, 1'b1);
        check("midrst load_ack", load_ack, 1'b0);
        check("midrst frame_done", frame_done, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst off an", an, 4'hF);
        cur_seg = {4{7'h40}};
        cur_dp  = 4'hF;
        for (int d = 0; d < 4; d++) step_digit(1'b0, 1'b0, 1'b0, 1'b0, d, "post_rst");
        step_digit(1'b0, 1'b0, 1'b1, 1'b0, 0, "post_rst_wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
